// File: rtl/fp_div_sqrt_share_controller.sv
// fp_div_sqrt_share_controller: round-robin ownership arbiter and launch/hold controller
// that shares one iterative FP divide/sqrt core among the FP issue lanes.
module fp_div_sqrt_share_controller #(
    parameter int LANES      = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [LANES-1:0]            reserve_req,
    output logic [LANES-1:0]            reserved,
    input  logic [LANES-1:0]            req,
    input  logic [LANES*DATA_WIDTH-1:0] data_a,
    input  logic [LANES*DATA_WIDTH-1:0] data_b,
    input  logic [LANES-1:0]            is_divide,
    input  logic [LANES*3-1:0]          rm,
    input  logic [LANES-1:0]            flush,
    input  logic [LANES-1:0]            release_in,
    output logic [LANES-1:0]            finished,
    output logic [DATA_WIDTH-1:0]       data_out,
    output logic [4:0]                  fflags_out,
    output logic                        core_start,
    output logic [DATA_WIDTH-1:0]       core_data_a,
    output logic [DATA_WIDTH-1:0]       core_data_b,
    output logic                        core_is_divide,
    output logic [2:0]                  core_rm,
    input  logic                        core_done,
    input  logic [DATA_WIDTH-1:0]       core_result,
    input  logic [4:0]                  core_fflags,
    output logic                        busy
);
    localparam int OW = LANES > 1 ? $clog2(LANES) : 1;

    typedef enum logic [2:0] {FREE, RESERVED, EXEC, DONE, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [OW-1:0]         owner_q, owner_d, rr_ptr_q, rr_ptr_d, pick;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, dout_q, dout_d;
    logic [4:0]            flg_q, flg_d;
    logic [2:0]            rm_q, rm_d;
    logic                  div_q, div_d, start_q, start_d;
    logic [2*LANES-1:0]    rot;
    logic [LANES-1:0]      own_oh;
    logic                  found, fl, rq, rl;
    int                    off, sum;

    // Rotating the doubled request vector by rr_ptr makes offset 0 the highest priority.
    always_comb begin
        rot   = {reserve_req, reserve_req} >> rr_ptr_q;
        off   = 0;
        found = 1'b0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off   = i;
                found = 1'b1;
            end
        end
        sum  = int'(rr_ptr_q) + off;
        pick = OW'(sum >= LANES ? sum - LANES : sum);
    end

    assign own_oh = LANES'(1) << owner_q;
    assign fl     = flush[owner_q];
    assign rq     = req[owner_q];
    assign rl     = release_in[owner_q];

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        a_d      = a_q;
        b_d      = b_q;
        div_d    = div_q;
        rm_d     = rm_q;
        dout_d   = dout_q;
        flg_d    = flg_q;
        start_d  = 1'b0;
        case (state_q)
            FREE: if (found) begin
                owner_d  = pick;
                rr_ptr_d = (int'(pick) == LANES - 1) ? '0 : pick + 1'b1;
                state_d  = RESERVED;
            end
            RESERVED: if (fl) begin
                state_d = FREE;
            end else if (rq) begin
                a_d     = data_a[owner_q*DATA_WIDTH +: DATA_WIDTH];
                b_d     = data_b[owner_q*DATA_WIDTH +: DATA_WIDTH];
                div_d   = is_divide[owner_q];
                rm_d    = rm[owner_q*3 +: 3];
                start_d = 1'b1;
                state_d = EXEC;
            end
            EXEC: if (fl) begin
                state_d = core_done ? FREE : DRAIN;
            end else if (core_done) begin
                dout_d  = core_result;
                flg_d   = core_fflags;
                state_d = DONE;
            end
            DONE:    state_d = (fl || rl) ? FREE : DONE;
            DRAIN:   state_d = core_done ? FREE : DRAIN;
            default: state_d = FREE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FREE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            div_q    <= 1'b0;
            rm_q     <= '0;
            dout_q   <= '0;
            flg_q    <= '0;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            div_q    <= div_d;
            rm_q     <= rm_d;
            dout_q   <= dout_d;
            flg_q    <= flg_d;
            start_q  <= start_d;
        end
    end

    assign reserved       = (state_q == RESERVED || state_q == EXEC || state_q == DONE) ? own_oh : '0;
    assign finished       = (state_q == DONE) ? own_oh : '0;
    assign busy           = state_q != FREE;
    assign core_start     = start_q;
    assign core_data_a    = a_q;
    assign core_data_b    = b_q;
    assign core_is_divide = div_q;
    assign core_rm        = rm_q;
    assign data_out       = dout_q;
    assign fflags_out     = flg_q;

    // A completion with no op in flight means the core broke its protocol.
    assert property (@(posedge clk) disable iff (rst)
        core_done |-> !(state_q == FREE || state_q == RESERVED));
endmodule

// File: tb/tb_fp_div_sqrt_share_controller.sv
// tb_fp_div_sqrt_share_controller: directed vector table plus hand-written drain and
// async-reset sequences for the shared div/sqrt controller (LANES=2).
module tb_fp_div_sqrt_share_controller;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  reserve_req, reserved, req, is_divide, flush, release_in, finished;
    logic [63:0] data_a, data_b;
    logic [5:0]  rm;
    logic [31:0] data_out, core_data_a, core_data_b, core_result;
    logic [4:0]  fflags_out, core_fflags;
    logic        core_start, core_is_divide, core_done, busy;
    logic [2:0]  core_rm;

    int n_vec = 0;
    int n_err = 0;

    fp_div_sqrt_share_controller #(.LANES(2), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .reserve_req(reserve_req), .reserved(reserved),
        .req(req), .data_a(data_a), .data_b(data_b), .is_divide(is_divide),
        .rm(rm), .flush(flush), .release_in(release_in), .finished(finished),
        .data_out(data_out), .fflags_out(fflags_out), .core_start(core_start),
        .core_data_a(core_data_a), .core_data_b(core_data_b),
        .core_is_divide(core_is_divide), .core_rm(core_rm), .core_done(core_done),
        .core_result(core_result), .core_fflags(core_fflags), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  rsv, rq, dv, fl, rl;
        logic        dn;
        logic [31:0] res;
        logic [4:0]  flg;
        logic [1:0]  e_res, e_fin;
        logic        e_st, e_busy;
        logic [31:0] e_dout;
        logic [4:0]  e_flg;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [1:0] rsv, logic [1:0] rq, logic [1:0] dv,
                                logic [1:0] fl, logic [1:0] rl, logic dn,
                                logic [31:0] res, logic [4:0] flg,
                                logic [1:0] e_res, logic [1:0] e_fin, logic e_st,
                                logic e_busy, logic [31:0] e_dout, logic [4:0] e_flg);
        vec_t v;
        v.rsv = rsv; v.rq = rq; v.dv = dv; v.fl = fl; v.rl = rl; v.dn = dn;
        v.res = res; v.flg = flg; v.e_res = e_res; v.e_fin = e_fin; v.e_st = e_st;
        v.e_busy = e_busy; v.e_dout = e_dout; v.e_flg = e_flg;
        return v;
    endfunction

    task automatic drive(logic [1:0] rsv, logic [1:0] rq, logic [1:0] dv, logic [1:0] fl,
                         logic [1:0] rl, logic dn, logic [31:0] res, logic [4:0] flg);
        reserve_req = rsv; req = rq; is_divide = dv; flush = fl; release_in = rl;
        core_done = dn; core_result = res; core_fflags = flg;
    endtask

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        data_a = {32'h41000000, 32'h40400000};
        data_b = {32'h00000000, 32'h40000000};
        rm     = {3'd4, 3'd1};
        drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 5'h0);

        // columns: rsv rq dv fl rl dn res flg | reserved finished start busy dout flags
        tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 32'h0, 5'h0, 2'b00, 2'b00, 0, 0, 32'h0, 5'h0));
        tbl.push_back(mk(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, 32'h0, 5'h0, 2'b01, 2'b00, 0, 1, 32'h0, 5'h0));
        tbl.push_back(mk(2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 0, 32'h0, 5'h0, 2'b01, 2'b00, 0, 1, 32'h0, 5'h0));
        tbl.push_back(mk(2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0, 32'h0, 5'h0, 2'b01, 2'b00, 1, 1, 32'h0, 5'h0));
        tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 32'h0, 5'h0, 2'b01, 2'b00, 0, 1, 32'h0, 5'h0));
        tbl.push_back(mk(2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 0, 32'h0, 5'h0, 2'b01, 2'b00, 0, 1, 32'h0, 5'h0));
        tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 0, 32'h0, 5'h0, 2'b01, 2'b00, 0, 1, 32'h0, 5'h0));
        for (int i = 0; i < 6; i++)
            tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 32'h0, 5'h0, 2'b01, 2'b00, 0, 1, 32'h0, 5'h0));
        tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 32'h3FC00000, 5'h01, 2'b01, 2'b01, 0, 1, 32'h3FC00000, 5'h01));
        tbl.push_back(mk(2'b10, 2'b01, 2'b00, 2'b10, 2'b10, 0, 32'h0, 5'h0, 2'b01, 2'b01, 0, 1, 32'h3FC00000, 5'h01));
        tbl.push_back(mk(2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 0, 32'h0, 5'h0, 2'b00, 2'b00, 0, 0, 32'h3FC00000, 5'h01));
        tbl.push_back(mk(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, 32'h0, 5'h0, 2'b10, 2'b00, 0, 1, 32'h3FC00000, 5'h01));
        // both lanes request continuously: grants must alternate
        tbl.push_back(mk(2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 0, 32'h0, 5'h0, 2'b10, 2'b00, 1, 1, 32'h3FC00000, 5'h01));
        tbl.push_back(mk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1, 32'h3FB504F3, 5'h00, 2'b10, 2'b10, 0, 1, 32'h3FB504F3, 5'h00));
        tbl.push_back(mk(2'b11, 2'b00, 2'b00, 2'b00, 2'b10, 0, 32'h0, 5'h0, 2'b00, 2'b00, 0, 0, 32'h3FB504F3, 5'h00));
        tbl.push_back(mk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 0, 32'h0, 5'h0, 2'b01, 2'b00, 0, 1, 32'h3FB504F3, 5'h00));
        tbl.push_back(mk(2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 0, 32'h0, 5'h0, 2'b01, 2'b00, 1, 1, 32'h3FB504F3, 5'h00));
        tbl.push_back(mk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1, 32'h40000000, 5'h10, 2'b01, 2'b01, 0, 1, 32'h40000000, 5'h10));
        tbl.push_back(mk(2'b11, 2'b00, 2'b00, 2'b00, 2'b01, 0, 32'h0, 5'h0, 2'b00, 2'b00, 0, 0, 32'h40000000, 5'h10));
        tbl.push_back(mk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 0, 32'h0, 5'h0, 2'b10, 2'b00, 0, 1, 32'h40000000, 5'h10));
        // flush beats req in RESERVED, then flush with core_done in EXEC
        tbl.push_back(mk(2'b11, 2'b10, 2'b00, 2'b10, 2'b00, 0, 32'h0, 5'h0, 2'b00, 2'b00, 0, 0, 32'h40000000, 5'h10));
        tbl.push_back(mk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 0, 32'h0, 5'h0, 2'b01, 2'b00, 0, 1, 32'h40000000, 5'h10));
        tbl.push_back(mk(2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0, 32'h0, 5'h0, 2'b01, 2'b00, 1, 1, 32'h40000000, 5'h10));
        tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1, 32'hDEADBEEF, 5'h1F, 2'b00, 2'b00, 0, 0, 32'h40000000, 5'h10));
        tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 32'h0, 5'h0, 2'b00, 2'b00, 0, 0, 32'h40000000, 5'h10));
        // flush in DONE
        tbl.push_back(mk(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, 32'h0, 5'h0, 2'b10, 2'b00, 0, 1, 32'h40000000, 5'h10));
        tbl.push_back(mk(2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 0, 32'h0, 5'h0, 2'b10, 2'b00, 1, 1, 32'h40000000, 5'h10));
        tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 32'h12345678, 5'h02, 2'b10, 2'b10, 0, 1, 32'h12345678, 5'h02));
        tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 0, 32'h0, 5'h0, 2'b00, 2'b00, 0, 0, 32'h12345678, 5'h02));

        rst = 1'b1;
        #2;
        chk("reset_outputs", {reserved, finished, core_start, busy, data_out, fflags_out, core_data_a},
            64'h0);
        #10 rst = 1'b0;

        foreach (tbl[k]) begin
            drive(tbl[k].rsv, tbl[k].rq, tbl[k].dv, tbl[k].fl, tbl[k].rl, tbl[k].dn,
                  tbl[k].res, tbl[k].flg);
            tick();
            n_vec++;
            if ({reserved, finished, core_start, busy, data_out, fflags_out} !==
                {tbl[k].e_res, tbl[k].e_fin, tbl[k].e_st, tbl[k].e_busy, tbl[k].e_dout, tbl[k].e_flg}) begin
                n_err++;
                $display("FAIL vec%0d: got rsv=%b fin=%b st=%b busy=%b dout=%h flg=%h expected rsv=%b fin=%b st=%b busy=%b dout=%h flg=%h",
                         k, reserved, finished, core_start, busy, data_out, fflags_out,
                         tbl[k].e_res, tbl[k].e_fin, tbl[k].e_st, tbl[k].e_busy, tbl[k].e_dout, tbl[k].e_flg);
            end
        end

        // flush during EXEC: drain until the late core_done, no grant meanwhile
        drive(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 5'h0);
        tick();
        chk("drain_grant", reserved, 2'b01);
        drive(2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 32'h0, 5'h0);
        tick();
        chk("launch_start", core_start, 1'b1);
        chk("launch_ops", {core_data_a, core_data_b}, {32'h40400000, 32'h40000000});
        chk("launch_ctl", {core_is_divide, core_rm}, {1'b1, 3'd1});
        drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 5'h0);
        tick();
        chk("start_one_cycle", core_start, 1'b0);
        tick();
        drive(2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 32'h0, 5'h0);
        tick();
        chk("flush_exec", {reserved, busy}, {2'b00, 1'b1});
        drive(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 5'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("drain_no_grant", {reserved, finished, busy}, {2'b00, 2'b00, 1'b1});
        end
        drive(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 32'hCAFEF00D, 5'h04);
        tick();
        chk("drain_done", {reserved, finished, busy, data_out}, {2'b00, 2'b00, 1'b0, 32'h12345678});
        drive(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 5'h0);
        tick();
        chk("post_drain_grant", reserved, 2'b10);

        // async reset between edges while lane1 is in EXEC
        drive(2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 5'h0);
        tick();
        chk("pre_reset_exec", {core_start, core_data_a}, {1'b1, 32'h41000000});
        drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 5'h0);
        #2 rst = 1'b1;
        #1;
        chk("async_reset", {reserved, finished, core_start, busy, data_out, fflags_out},
            64'h0);
        chk("async_reset_core", {core_data_a, core_is_divide, core_rm}, 64'h0);
        #2 rst = 1'b0;
        drive(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 5'h0);
        tick();
        chk("reset_regrant", reserved, 2'b01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
